// File: rtl/store_bmp.sv
// Serialises an IMG_WIDTH x IMG_HEIGHT pixel memory into a 24-bit uncompressed BMP byte stream:
// a 54-byte header, then bottom-up rows of B,G,R bytes, each row zero-padded to a 4-byte multiple.
module store_bmp #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int ADDR_WIDTH = 18,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  pix_rd_en,
    output logic [ADDR_WIDTH-1:0] pix_addr,
    input  logic [23:0]           pix_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BYTE_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [31:0] ROW_BYTES = 32'(3 * IMG_WIDTH);
    localparam logic [31:0] PAD       = (32'd4 - (ROW_BYTES % 32'd4)) % 32'd4;
    localparam logic [31:0] IMG_SIZE  = (ROW_BYTES + PAD) * 32'(IMG_HEIGHT);
    localparam logic [31:0] FILE_SIZE = 32'd54 + IMG_SIZE;
    localparam logic [31:0] WIDTH32   = 32'(IMG_WIDTH);
    localparam logic [31:0] HEIGHT32  = 32'(IMG_HEIGHT);
    localparam logic [31:0] PPM       = 32'd2835;

    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'((IMG_HEIGHT - 1) * IMG_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ROW_BACK   = ADDR_WIDTH'(2 * IMG_WIDTH - 1);
    localparam logic [11:0]           LAST_COL   = 12'(IMG_WIDTH - 1);
    localparam logic [11:0]           LAST_ROW   = 12'(IMG_HEIGHT - 1);
    localparam logic [1:0]            LAST_PAD   = 2'(PAD - 32'd1);
    localparam logic [5:0]            HDR_LAST   = 6'd53;
    localparam logic [5:0]            HDR_PREFETCH = 6'd52;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PIXEL,
        S_PAD,
        S_DONE
    } state_t;

    state_t                  state_q,    state_d;
    logic [5:0]              hdr_cnt_q,  hdr_cnt_d;
    logic [11:0]             row_q,      row_d;
    logic [11:0]             col_q,      col_d;
    logic [1:0]              byte_sel_q, byte_sel_d;
    logic [1:0]              pad_cnt_q,  pad_cnt_d;
    logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
    logic [23:0]             cur_pix_q,  cur_pix_d;
    logic [23:0]             nxt_pix_q,  nxt_pix_d;
    logic                    rd_pend_q,  rd_pend_d;

    logic                    accept;
    logic                    last_col;
    logic                    last_row;
    logic                    last_pixel;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic [7:0]              out_byte;

    function automatic logic [7:0] field_byte(input logic [31:0] value, input logic [1:0] k);
        return value[8*k +: 8];
    endfunction

    function automatic logic [7:0] header_byte(input logic [5:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            6'd0:                      b = 8'h42;
            6'd1:                      b = 8'h4D;
            6'd2, 6'd3, 6'd4, 6'd5:    b = field_byte(FILE_SIZE, 2'(idx - 6'd2));
            6'd10:                     b = 8'd54;
            6'd14:                     b = 8'd40;
            6'd18, 6'd19, 6'd20, 6'd21: b = field_byte(WIDTH32, 2'(idx - 6'd18));
            6'd22, 6'd23, 6'd24, 6'd25: b = field_byte(HEIGHT32, 2'(idx - 6'd22));
            6'd26:                     b = 8'd1;
            6'd28:                     b = 8'd24;
            6'd34, 6'd35, 6'd36, 6'd37: b = field_byte(IMG_SIZE, 2'(idx - 6'd34));
            6'd38, 6'd39, 6'd40, 6'd41: b = field_byte(PPM, 2'(idx - 6'd38));
            6'd42, 6'd43, 6'd44, 6'd45: b = field_byte(PPM, 2'(idx - 6'd42));
            default:                   b = 8'h00;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hdr_cnt_q  <= '0;
            row_q      <= '0;
            col_q      <= '0;
            byte_sel_q <= '0;
            pad_cnt_q  <= '0;
            cur_addr_q <= '0;
            cur_pix_q  <= '0;
            nxt_pix_q  <= '0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            byte_sel_q <= byte_sel_d;
            pad_cnt_q  <= pad_cnt_d;
            cur_addr_q <= cur_addr_d;
            cur_pix_q  <= cur_pix_d;
            nxt_pix_q  <= nxt_pix_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        row_d      = row_q;
        col_d      = col_q;
        byte_sel_d = byte_sel_q;
        pad_cnt_d  = pad_cnt_q;
        cur_addr_d = cur_addr_q;
        cur_pix_d  = cur_pix_q;
        out_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        pix_rd_en  = 1'b0;
        pix_addr   = '0;
        out_byte   = 8'h00;

        last_col   = (col_q == LAST_COL);
        last_row   = (row_q == 12'd0);
        last_pixel = last_col && last_row;
        next_addr  = last_col ? (cur_addr_q - ROW_BACK) : (cur_addr_q + ADDR_WIDTH'(1));

        // A read response is captured the cycle after its strobe; the bypass lets the
        // first pixel be consumed in that same cycle without a bubble after the header.
        nxt_pix_d  = rd_pend_q ? pix_data : nxt_pix_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_HEADER;
                    hdr_cnt_d  = '0;
                    row_d      = LAST_ROW;
                    col_d      = '0;
                    byte_sel_d = '0;
                    pad_cnt_d  = '0;
                    cur_addr_d = FIRST_ADDR;
                end
            end
            S_HEADER: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_byte  = header_byte(hdr_cnt_q);
                pix_rd_en = (hdr_cnt_q == HDR_PREFETCH);
                pix_addr  = FIRST_ADDR;
            end
            S_PIXEL: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                case (byte_sel_q)
                    2'd0:    out_byte = cur_pix_q[7:0];
                    2'd1:    out_byte = cur_pix_q[15:8];
                    default: out_byte = cur_pix_q[23:16];
                endcase
                // Fetch the following pixel while its predecessor's B byte is on the bus.
                pix_rd_en = (byte_sel_q == 2'd0) && !last_pixel;
                pix_addr  = next_addr;
            end
            S_PAD: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        accept = out_valid && out_ready;

        if (accept) begin
            case (state_q)
                S_HEADER: begin
                    if (hdr_cnt_q == HDR_LAST) begin
                        state_d   = S_PIXEL;
                        cur_pix_d = nxt_pix_d;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 6'd1;
                    end
                end
                S_PIXEL: begin
                    if (byte_sel_q != 2'd2) begin
                        byte_sel_d = byte_sel_q + 2'd1;
                    end else begin
                        byte_sel_d = '0;
                        cur_pix_d  = nxt_pix_d;
                        cur_addr_d = next_addr;
                        if (!last_col) begin
                            col_d = col_q + 12'd1;
                        end else begin
                            col_d = '0;
                            if (PAD != 32'd0) begin
                                state_d   = S_PAD;
                                pad_cnt_d = '0;
                            end else if (last_row) begin
                                state_d = S_DONE;
                            end else begin
                                row_d = row_q - 12'd1;
                            end
                        end
                    end
                end
                S_PAD: begin
                    if (pad_cnt_q == LAST_PAD) begin
                        pad_cnt_d = '0;
                        if (last_row) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_PIXEL;
                            row_d   = row_q - 12'd1;
                        end
                    end else begin
                        pad_cnt_d = pad_cnt_q + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end

        rd_pend_d = pix_rd_en;
        out_data  = BYTE_WIDTH'(out_byte);
    end

endmodule

// File: tb/tb_store_bmp.sv
// Self-checking bench for store_bmp: a 3x2 instance (padded rows) and a 4x1 instance (no padding),
// with a byte scoreboard, a table of fixed file bytes, and handshake/reset/start corner sequences.
module tb_store_bmp;

    localparam int WA = 3;
    localparam int HA = 2;
    localparam int WB = 4;
    localparam int HB = 1;
    localparam int FILE_A = 78;
    localparam int FILE_B = 66;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        ready_a;
    logic        ready_b = 1'b1;
    logic        rd_en_a, rd_en_b;
    logic [17:0] addr_a, addr_b;
    logic [23:0] pix_a = '0;
    logic [23:0] pix_b = '0;
    logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [7:0]  data_a, data_b;

    always #5 clk = ~clk;

    store_bmp #(.IMG_WIDTH(WA), .IMG_HEIGHT(HA), .ADDR_WIDTH(18), .BYTE_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .pix_rd_en(rd_en_a), .pix_addr(addr_a), .pix_data(pix_a),
        .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a),
        .busy(busy_a), .done(done_a)
    );

    store_bmp #(.IMG_WIDTH(WB), .IMG_HEIGHT(HB), .ADDR_WIDTH(18), .BYTE_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .pix_rd_en(rd_en_b), .pix_addr(addr_b), .pix_data(pix_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b),
        .busy(busy_b), .done(done_b)
    );

    int checkCnt = 0;
    int passCnt  = 0;
    int cyc      = 0;
    bit randMode = 1'b0;

    logic [7:0] expA[$];
    logic [7:0] expB[$];
    logic [7:0] logA[$];
    logic [7:0] logB[$];
    logic [7:0] run1Log[$];

    int doneCntA = 0;
    int doneCntB = 0;
    int doneCycA = 0;
    int doneCycB = 0;
    int riseCycA = 0;
    int riseCycB = 0;
    bit prevValidA = 1'b0;
    bit prevValidB = 1'b0;
    bit holdA = 1'b0;
    logic [7:0] heldA = '0;

    typedef struct {
        bit         onB;
        int         idx;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] memVal(input int a);
        logic [7:0] k;
        k = 8'(a);
        return {8'hA0 + k, 8'h50 + k, 8'h10 + k};
    endfunction

    always @(posedge clk) if (rd_en_a) pix_a <= memVal(int'(addr_a));
    always @(posedge clk) if (rd_en_b) pix_b <= memVal(int'(addr_b));

    initial begin
        ready_a = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_a = randMode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Expected-stream builder: header fields from the BMP layout, then rows bottom-up, B,G,R, zero pad.
    task automatic pushFile(input int w, input int h, input bit toB);
        int rowb, pad, img, fsz;
        logic [7:0]  hb[54];
        logic [23:0] v;
        logic [7:0]  q[$];
        rowb = 3 * w;
        pad  = (4 - rowb % 4) % 4;
        img  = (rowb + pad) * h;
        fsz  = 54 + img;
        foreach (hb[i]) hb[i] = 8'h00;
        hb[0] = 8'h42;
        hb[1] = 8'h4D;
        for (int k = 0; k < 4; k++) begin
            hb[2 + k]  = 8'(fsz >> (8 * k));
            hb[10 + k] = 8'(54 >> (8 * k));
            hb[14 + k] = 8'(40 >> (8 * k));
            hb[18 + k] = 8'(w >> (8 * k));
            hb[22 + k] = 8'(h >> (8 * k));
            hb[34 + k] = 8'(img >> (8 * k));
            hb[38 + k] = 8'(2835 >> (8 * k));
            hb[42 + k] = 8'(2835 >> (8 * k));
        end
        hb[26] = 8'd1;
        hb[28] = 8'd24;
        foreach (hb[i]) q.push_back(hb[i]);
        for (int r = h - 1; r >= 0; r--) begin
            for (int c = 0; c < w; c++) begin
                v = memVal(r * w + c);
                q.push_back(v[7:0]);
                q.push_back(v[15:8]);
                q.push_back(v[23:16]);
            end
            for (int p = 0; p < pad; p++) q.push_back(8'h00);
        end
        foreach (q[i]) begin
            if (toB) expB.push_back(q[i]);
            else     expA.push_back(q[i]);
        end
    endtask

    task automatic addVec(input bit onB, input int idx, input logic [7:0] e);
        vec_t v;
        v.onB = onB;
        v.idx = idx;
        v.exp = e;
        vecs.push_back(v);
    endtask

    // Monitors sample mid-cycle; a byte seen with valid&&ready here is the one accepted at the next edge.
    always @(negedge clk) begin
        if (holdA) begin
            checkOutput("stall_valid_hold", 32'(valid_a), 32'd1);
            checkOutput("stall_data_hold", 32'(data_a), 32'(heldA));
        end
        holdA = valid_a && !ready_a;
        heldA = data_a;
        if (valid_a && !prevValidA) riseCycA = cyc;
        prevValidA = valid_a;
        if (valid_a && ready_a) begin
            logA.push_back(data_a);
            if (expA.size() == 0) checkOutput("sb_a_extra_byte", 32'd1, 32'd0);
            else checkOutput("sb_a_byte", 32'(data_a), 32'(expA.pop_front()));
        end
        if (done_a) begin
            doneCntA++;
            doneCycA = cyc;
            checkOutput("done_a_busy_low", 32'(busy_a), 32'd0);
        end
        if (rd_en_a) begin
            checkOutput("rd_a_while_busy", 32'(busy_a), 32'd1);
            checkOutput("rd_a_addr_range", 32'(addr_a < 18'(WA * HA)), 32'd1);
        end
    end

    always @(negedge clk) begin
        if (valid_b && !prevValidB) riseCycB = cyc;
        prevValidB = valid_b;
        if (valid_b && ready_b) begin
            logB.push_back(data_b);
            if (expB.size() == 0) checkOutput("sb_b_extra_byte", 32'd1, 32'd0);
            else checkOutput("sb_b_byte", 32'(data_b), 32'(expB.pop_front()));
        end
        if (done_b) begin
            doneCntB++;
            doneCycB = cyc;
        end
        if (rd_en_b) checkOutput("rd_b_while_busy", 32'(busy_b), 32'd1);
    end

    task automatic applyStimulus(input bit onB, output int k);
        if (onB) start_b = 1'b1;
        else     start_a = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic waitDoneA(input int maxc, input string nm);
        int d0;
        d0 = doneCntA;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk);
            #1;
            if (doneCntA != d0) break;
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput(nm, 32'(doneCntA - d0), 32'd1);
    endtask

    task automatic waitBytesA(input int n, input int maxc, input string nm);
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk);
            #1;
            if (logA.size() >= n) break;
        end
        checkOutput(nm, 32'(logA.size() >= n), 32'd1);
    endtask

    initial begin
        int kA, kB, d0, diffs;
        logic [7:0] hdrA[6];
        logic [7:0] pixRef[24];
        logic [31:0] act;

        hdrA   = '{8'h42, 8'h4D, 8'h4E, 8'h00, 8'h00, 8'h00};
        pixRef = '{8'h13, 8'h53, 8'hA3, 8'h14, 8'h54, 8'hA4, 8'h15, 8'h55, 8'hA5, 8'h00, 8'h00, 8'h00,
                   8'h10, 8'h50, 8'hA0, 8'h11, 8'h51, 8'hA1, 8'h12, 8'h52, 8'hA2, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) addVec(1'b0, i, hdrA[i]);
        addVec(1'b0, 10, 8'h36); addVec(1'b0, 11, 8'h00); addVec(1'b0, 12, 8'h00); addVec(1'b0, 13, 8'h00);
        addVec(1'b0, 34, 8'h18); addVec(1'b0, 35, 8'h00); addVec(1'b0, 36, 8'h00); addVec(1'b0, 37, 8'h00);
        for (int i = 0; i < 24; i++) addVec(1'b0, 54 + i, pixRef[i]);
        addVec(1'b1, 2, 8'h42); addVec(1'b1, 3, 8'h00); addVec(1'b1, 4, 8'h00); addVec(1'b1, 5, 8'h00);
        addVec(1'b1, 18, 8'h04); addVec(1'b1, 22, 8'h01); addVec(1'b1, 34, 8'h0C);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", 32'(valid_a), 32'd0);
        checkOutput("reset_busy", 32'(busy_a), 32'd0);
        checkOutput("reset_done", 32'(done_a), 32'd0);
        checkOutput("reset_rd_en", 32'(rd_en_a), 32'd0);
        checkOutput("reset_data", 32'(data_a), 32'd0);
        checkOutput("reset_b_valid", 32'(valid_b), 32'd0);

        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("start_with_rst_valid", 32'(valid_a), 32'd0);
        checkOutput("start_with_rst_busy", 32'(busy_a), 32'd0);

        $display("[TB] run 1: 3x2, out_ready held high");
        d0 = doneCntA;
        pushFile(WA, HA, 1'b0);
        applyStimulus(1'b0, kA);
        for (int i = 0; i < 200; i++) begin
            if (done_a) break;
            @(posedge clk);
            #1;
        end
        checkOutput("run1_done_seen", 32'(done_a), 32'd1);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        checkOutput("start_in_done_valid", 32'(valid_a), 32'd0);
        checkOutput("start_in_done_busy", 32'(busy_a), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("start_in_done_still_idle", 32'(valid_a), 32'd0);
        checkOutput("run1_done_count", 32'(doneCntA - d0), 32'd1);
        checkOutput("run1_first_valid_cycle", 32'(riseCycA - kA), 32'd0);
        checkOutput("run1_done_cycle", 32'(doneCycA - kA), 32'(FILE_A));
        checkOutput("run1_byte_count", 32'(logA.size()), 32'(FILE_A));
        checkOutput("run1_sb_drained", 32'(expA.size()), 32'd0);
        run1Log = logA;

        $display("[TB] run 2: 3x2, random out_ready");
        logA.delete();
        randMode = 1'b1;
        pushFile(WA, HA, 1'b0);
        applyStimulus(1'b0, kA);
        waitDoneA(2000, "run2_single_done");
        randMode = 1'b0;
        checkOutput("run2_byte_count", 32'(logA.size()), 32'(FILE_A));
        diffs = (logA.size() == run1Log.size()) ? 0 : 1;
        for (int i = 0; i < logA.size() && i < run1Log.size(); i++)
            if (logA[i] !== run1Log[i]) diffs++;
        checkOutput("run2_stream_identical", 32'(diffs), 32'd0);

        $display("[TB] run 3: start re-pulsed while busy");
        logA.delete();
        pushFile(WA, HA, 1'b0);
        applyStimulus(1'b0, kA);
        waitBytesA(20, 200, "run3_reach_byte20");
        applyStimulus(1'b0, kB);
        waitDoneA(200, "run3_single_done");
        checkOutput("run3_byte_count", 32'(logA.size()), 32'(FILE_A));
        checkOutput("run3_sb_drained", 32'(expA.size()), 32'd0);
        checkOutput("run3_idle_after", 32'(valid_a), 32'd0);

        $display("[TB] run 4: reset mid-file, then a fresh file");
        logA.delete();
        pushFile(WA, HA, 1'b0);
        applyStimulus(1'b0, kA);
        waitBytesA(60, 200, "run4_reach_byte60");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_valid", 32'(valid_a), 32'd0);
        checkOutput("abort_busy", 32'(busy_a), 32'd0);
        d0 = doneCntA;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 32'(doneCntA - d0), 32'd0);
        checkOutput("abort_stays_idle", 32'(valid_a), 32'd0);
        expA.delete();
        logA.delete();
        pushFile(WA, HA, 1'b0);
        applyStimulus(1'b0, kA);
        waitDoneA(200, "run4_restart_done");
        checkOutput("run4_byte_count", 32'(logA.size()), 32'(FILE_A));
        checkOutput("run4_first_byte", 32'(logA.size() > 0 ? logA[0] : 8'h00), 32'h42);
        checkOutput("run4_sb_drained", 32'(expA.size()), 32'd0);

        $display("[TB] run 5: 4x1 image without row padding");
        d0 = doneCntB;
        pushFile(WB, HB, 1'b1);
        applyStimulus(1'b1, kB);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (doneCntB != d0) break;
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput("run5_single_done", 32'(doneCntB - d0), 32'd1);
        checkOutput("run5_byte_count", 32'(logB.size()), 32'(FILE_B));
        checkOutput("run5_sb_drained", 32'(expB.size()), 32'd0);
        checkOutput("run5_first_valid_cycle", 32'(riseCycB - kB), 32'd0);
        checkOutput("run5_done_cycle", 32'(doneCycB - kB), 32'(FILE_B));

        foreach (vecs[i]) begin
            if (vecs[i].onB) act = (vecs[i].idx < logB.size()) ? 32'(logB[vecs[i].idx]) : 32'hFFFF_FFFF;
            else act = (vecs[i].idx < run1Log.size()) ? 32'(run1Log[vecs[i].idx]) : 32'hFFFF_FFFF;
            checkOutput($sformatf("vec_%s_byte%0d", vecs[i].onB ? "4x1" : "3x2", vecs[i].idx),
                        act, 32'(vecs[i].exp));
        end

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
